// File: rtl/pmp_check_arbiter_if.sv
// Requester-side handshake bundle for the shared PMP checker: request channel
// (valid/ready + addr/access/priv) and response channel (valid/ready + allow).
interface pmp_check_arbiter_if #(
    parameter int NrReq = 3,
    parameter int PLEN  = 34
);
    logic [NrReq-1:0]           req_valid;
    logic [NrReq-1:0]           req_ready;
    logic [NrReq-1:0][PLEN-1:0] req_addr;
    logic [NrReq-1:0][2:0]      req_access;   // {x, w, r}
    logic [NrReq-1:0][1:0]      req_priv;
    logic [NrReq-1:0]           resp_valid;
    logic [NrReq-1:0]           resp_ready;
    logic                       resp_allow;

    modport master (
        output req_valid, req_addr, req_access, req_priv, resp_ready,
        input  req_ready, resp_valid, resp_allow
    );

    modport slave (
        input  req_valid, req_addr, req_access, req_priv, resp_ready,
        output req_ready, resp_valid, resp_allow
    );
endinterface

// File: rtl/pmp_check_arbiter.sv
// Round-robin front end sharing one combinational PMP checker between the PTW,
// LSU and fetch; registered request, registered allow/deny response.
package config_pkg;
    localparam int PLEN         = 34;
    localparam int NrPMPEntries = 8;

    typedef logic [2:0] pmp_access_t;  // {x, w, r}

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        A_OFF   = 2'b00,
        A_TOR   = 2'b01,
        A_NA4   = 2'b10,
        A_NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmp_access_t    access_type;
    } pmpcfg_t;
endpackage

// Address match for one PMP entry; pmpaddr values hold address bits [PLEN-1:2].
module pmp_check_arbiter_entry #(
    parameter int PLEN = 34
) (
    input  logic [PLEN-1:0] i_addr,
    input  logic [PLEN-3:0] i_conf_addr,
    input  logic [PLEN-3:0] i_prev_addr,
    input  logic [1:0]      i_mode,
    output logic            o_match
);
    logic [PLEN-3:0] w_napot_mask;
    logic [PLEN-1:0] w_base;
    logic [PLEN-1:0] w_top;

    // Trailing ones of pmpaddr plus the next bit are the don't-care word bits.
    assign w_napot_mask = i_conf_addr ^ (i_conf_addr + 1'b1);
    assign w_base       = {i_prev_addr, 2'b00};
    assign w_top        = {i_conf_addr, 2'b00};

    always_comb begin
        o_match = 1'b0;
        case (i_mode)
            config_pkg::A_TOR:   o_match = (i_addr >= w_base) && (i_addr < w_top);
            config_pkg::A_NA4:   o_match = (i_addr[PLEN-1:2] == i_conf_addr);
            config_pkg::A_NAPOT: o_match = ((i_addr[PLEN-1:2] ^ i_conf_addr) & ~w_napot_mask) == '0;
            default:             o_match = 1'b0;
        endcase
    end
endmodule

module pmp_check_arbiter
    import config_pkg::*;
#(
    parameter int NrReq        = 3,
    parameter int PLEN         = config_pkg::PLEN,
    parameter int NrPMPEntries = config_pkg::NrPMPEntries
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  flush_i,
    input  logic                                  csr_pmp_we_i,
    input  logic [NrPMPEntries-1:0][PLEN-3:0]     conf_addr_i,
    input  pmpcfg_t [NrPMPEntries-1:0]            conf_i,
    pmp_check_arbiter_if.slave                    bus
);
    localparam int IW = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam logic [NrReq-1:0] ONE = NrReq'(1);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

    state_e            r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_idx;
    logic [PLEN-1:0]   r_addr;
    logic [2:0]        r_access;
    logic [1:0]        r_priv;
    logic              r_allow;
    logic [NrReq-1:0]  r_resp_valid;

    logic              w_gnt_found;
    logic [IW-1:0]     w_gnt_idx;
    logic [NrReq-1:0]  w_req_ready;
    logic [NrPMPEntries-1:0] w_match;
    logic              w_allow;

    // ---------------- round-robin pick: first valid index after r_ptr
    always_comb begin
        int j;
        j           = 0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 1; k <= NrReq; k++) begin
            j = (int'(r_ptr) + k) % NrReq;
            if (!w_gnt_found && bus.req_valid[IW'(j)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IW'(j);
            end
        end
    end

    // Combinational grant: depends on req_valid in the same cycle.
    assign w_req_ready = (r_state == IDLE && !rst_i && !flush_i && !csr_pmp_we_i && w_gnt_found)
                       ? (ONE << w_gnt_idx) : '0;

    // ---------------- PMP checker on the latched request
    for (genvar e = 0; e < NrPMPEntries; e++) begin : g_entry
        logic [PLEN-3:0] w_prev;
        if (e == 0) begin : g_first
            assign w_prev = '0;
        end else begin : g_rest
            assign w_prev = conf_addr_i[e-1];
        end
        pmp_check_arbiter_entry #(.PLEN(PLEN)) u_entry (
            .i_addr      (r_addr),
            .i_conf_addr (conf_addr_i[e]),
            .i_prev_addr (w_prev),
            .i_mode      (conf_i[e].addr_mode),
            .o_match     (w_match[e])
        );
    end

    // First matching entry decides; M-mode bypasses unlocked entries.
    always_comb begin
        logic hit;
        hit     = 1'b0;
        w_allow = (r_priv == PRIV_M);
        for (int e = 0; e < NrPMPEntries; e++) begin
            if (!hit && w_match[e]) begin
                hit = 1'b1;
                if (r_priv == PRIV_M && !conf_i[e].locked)
                    w_allow = 1'b1;
                else
                    w_allow = (r_access & ~conf_i[e].access_type) == 3'b000;
            end
        end
    end

    // ---------------- control FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_ptr        <= IW'(NrReq - 1);
            r_idx        <= '0;
            r_addr       <= '0;
            r_access     <= '0;
            r_priv       <= '0;
            r_allow      <= 1'b0;
            r_resp_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req_ready) begin
                        r_addr   <= bus.req_addr[w_gnt_idx];
                        r_access <= bus.req_access[w_gnt_idx];
                        r_priv   <= bus.req_priv[w_gnt_idx];
                        r_idx    <= w_gnt_idx;
                        r_ptr    <= w_gnt_idx;
                        r_state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                    end else if (!csr_pmp_we_i) begin
                        // A CSR write this cycle makes the result stale: rerun.
                        r_allow      <= w_allow;
                        r_resp_valid <= ONE << r_idx;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (flush_i || bus.resp_ready[r_idx]) begin
                        r_resp_valid <= '0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_allow = r_allow;
endmodule

// File: doc/pmp_check_arbiter.md
# pmp_check_arbiter

Sequential front end that shares one combinational PMP checker between several requesters (page-table walker, LSU, instruction fetch) in the MMU. It arbitrates round-robin, registers the winning address, access type and privilege level, runs the PMP check against the live CSR configuration, and returns a registered allow/deny result to the granted requester with valid/ready back-pressure. It also handles aborts on pipeline flush and re-checks a request when the PMP CSRs are written while that request is in flight.

## Interface
- NrReq, 3, number of requesters; index 0 = PTW, 1 = LSU, 2 = fetch
- PLEN, config_pkg::PLEN, physical address width
- NrPMPEntries, config_pkg::NrPMPEntries, number of PMP entries

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  abort any in-flight check; no response is issued
- csr_pmp_we_i  in  1  a pmpcfg/pmpaddr CSR write takes effect this cycle
- conf_addr_i  in  NrPMPEntries x (PLEN-2)  pmpaddr values
- conf_i  in  NrPMPEntries x pmpcfg_t  pmpcfg values
- req_valid_i  in  NrReq  check requests
- req_ready_o  out  NrReq  grant, one-hot or zero
- req_addr_i  in  NrReq x PLEN  physical address per requester
- req_access_i  in  NrReq x pmp_access_t  access type (R/W/X)
- req_priv_i  in  NrReq x priv_lvl_t  effective privilege level
- resp_valid_o  out  NrReq  result valid, one-hot or zero
- resp_ready_i  in  NrReq  requester accepts the result
- resp_allow_o  out  1  result, meaningful only while any resp_valid_o is high

## Operation
- FSM states: IDLE, CHECK, RESP. Reset state is IDLE.
- IDLE:
  - If csr_pmp_we_i is 0 and any req_valid_i is high, grant the first valid index after the round-robin pointer (modulo NrReq).
  - req_ready_o[g] = 1 combinationally in the same cycle. This path depends on req_valid_i and is documented as such.
  - On the handshake, latch addr, access, priv and index g; set pointer = g; go to CHECK.
  - req_ready_o is 0 in every other state and whenever csr_pmp_we_i = 1.
- CHECK:
  - The internal pmp instance evaluates the latched request against the current conf_i and conf_addr_i.
  - If csr_pmp_we_i = 1 this cycle, discard the result and stay in CHECK, so the check reruns next cycle with the new configuration.
  - Otherwise register allow and go to RESP.
- RESP:
  - resp_valid_o[g] = 1 and resp_allow_o holds the registered result, stable until the handshake.
  - On resp_ready_i[g] go to IDLE.
  - A csr_pmp_we_i in RESP does not change the already-registered result.
- flush_i: from CHECK or RESP, go to IDLE next cycle. resp_valid_o drops with no handshake. The pointer is kept.
- flush_i in IDLE blocks the grant that cycle.
- Precedence: flush_i > csr_pmp_we_i > normal flow.
- Round-robin pointer resets to NrReq-1, so requester 0 wins first after reset.
- No requester can be granted twice in a row while another requester is waiting.
- Permission semantics are exactly those of the pmp checker:
  - First matching entry decides the result.
  - M-mode is exempt unless the matching entry is locked.
  - No match: allow in M-mode, deny otherwise.

## Timing
- Reset values: req_ready_o = 0, resp_valid_o = 0, resp_allow_o = 0, state = IDLE, pointer = NrReq-1, latched request = 0.
- Latency: handshake in cycle N, CHECK in N+1, resp_valid_o high from cycle N+2. Each cycle with csr_pmp_we_i high during CHECK adds one cycle.
- Throughput: at most one check in flight. The earliest next grant is the cycle after the response handshake (IDLE cycle), giving 3 cycles per check with resp_ready_i tied high.
- req_* inputs need to be stable only in the handshake cycle; they are sampled at that edge.
- Asserting reset mid-check clears all state immediately. No response is produced for the aborted request.

## Test plan
- Single request:
  - Stimulus: requester 1 (LSU), S-mode, W access to 0x8000_1000. Entry 0 is NAPOT covering 0x8000_0000–0x8000_FFFF with R only.
  - Required: req_ready_o = 3'b010 in cycle N; resp_valid_o = 3'b010 in cycle N+2; resp_allow_o = 0.
- Round-robin:
  - Stimulus: all three requesters hold valid continuously, resp_ready_i tied high.
  - Required: grant order 0, 1, 2, 0, 1, 2, with one grant every 3 cycles.
- CSR write during CHECK:
  - Stimulus: U-mode R access to an address with no matching entry, csr_pmp_we_i pulsed in the CHECK cycle, and the write adds a matching entry with R permission.
  - Required: response arrives one cycle late (N+3) with allow = 1.
- Back-pressure:
  - Stimulus: resp_ready_i[2] held at 0 for 5 cycles while requester 0 is also requesting.
  - Required: resp_valid_o[2] and resp_allow_o stay stable; req_ready_o[0] is not asserted until the cycle after the response handshake.
- Flush:
  - Stimulus: flush_i asserted in the CHECK cycle.
  - Required: no resp_valid_o pulse; FSM returns to IDLE; the next pending requester is granted the following cycle.
- Mid-operation reset:
  - Stimulus: rst_i asserted in the RESP state.
  - Required: all outputs are 0 immediately; after release, requester 0 wins the first arbitration.
